// File: rtl/vector_frame_ctrl.sv
// Frame accumulator in front of an external pipelined adder tree.
// Issues vectors, tracks in-flight results and reports one sum per frame.
module vector_frame_ctrl #(
  parameter  int VECTOR_LENGTH = 7,
  parameter  int DATA_WIDTH    = 16,
  parameter  int FRAME_W       = 8,
  localparam int LAT           = $clog2(VECTOR_LENGTH),
  localparam int SUM_W         = DATA_WIDTH + LAT,
  localparam int ACC_W         = SUM_W + FRAME_W,
  localparam int VW            = VECTOR_LENGTH * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FRAME_W-1:0] cfg_frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VW-1:0]    vector_in,
  output logic [VW-1:0]    tree_vector,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] frame_sum,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] frame_len;
  logic [FRAME_W-1:0] count;
  logic [LAT:0]       valid_pipe;
  logic [ACC_W-1:0]   acc;
  logic               hs;

  // in_ready is only ever high in RUN, so a handshake implies RUN
  assign hs = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_len   <= '0;
      count       <= '0;
      valid_pipe  <= '0;
      acc         <= '0;
      tree_vector <= '0;
      frame_sum   <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | (LAT+1)'(hs);
      if (valid_pipe[LAT])
        acc <= acc + ACC_W'(tree_sum);
      if (hs)
        tree_vector <= vector_in;
      unique case (state)
        IDLE: begin
          if (start) begin
            frame_len <= (cfg_frame_len == '0) ?
                         FRAME_W'(1) : cfg_frame_len;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            count <= count + FRAME_W'(1);
            if (count + FRAME_W'(1) == frame_len) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_pipe == '0) begin
            frame_sum <= acc;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_frame_ctrl.sv
// Bench for vector_frame_ctrl: external tree model, timeline model,
// per-cycle compare and directed frames with literal sums.
module tb_vector_frame_ctrl;

  localparam int VL    = 7;
  localparam int DW    = 16;
  localparam int FW    = 8;
  localparam int LAT   = $clog2(VL);
  localparam int SUM_W = DW + LAT;
  localparam int ACC_W = SUM_W + FW;
  localparam int VW    = VL * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [FW-1:0]    cfg_frame_len;
  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    vector_in;
  logic [VW-1:0]    tree_vector;
  logic [SUM_W-1:0] tree_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] frame_sum;
  logic             busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  vector_frame_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_frame_len(cfg_frame_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .vector_in(vector_in),
    .tree_vector(tree_vector),
    .tree_sum(tree_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_sum(frame_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic longint vsum(logic [VW-1:0] v);
    longint s = 0;
    for (int i = 0; i < VL; i++)
      s += longint'(v[i*DW +: DW]);
    return s;
  endfunction

  function automatic logic [VW-1:0] fill(logic [DW-1:0] e);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++)
      v[i*DW +: DW] = e;
    return v;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++)
      v[i*DW +: DW] = DW'(i + 1);
    return v;
  endfunction

  // External adder tree: LAT register stages, not reset
  logic [SUM_W-1:0] tp [LAT];
  always @(posedge clk) begin
    tp[0] <= SUM_W'(vsum(tree_vector));
    for (int i = 1; i < LAT; i++)
      tp[i] <= tp[i-1];
  end
  assign tree_sum = tp[LAT-1];

  // Model: frame sum taken directly at acceptance; result is
  // published LAT+2 edges after the last accepted vector.
  int               m_phase = 0;
  int               m_len   = 0;
  int               m_cnt   = 0;
  longint           m_acc   = 0;
  longint           cyc     = 0;
  longint           done_at = 0;
  logic [ACC_W-1:0] m_fs    = '0;
  logic [VW-1:0]    m_tv    = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_acc   = 0;
      m_fs    = '0;
      m_tv    = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_len   = (cfg_frame_len == 0) ? 1 : int'(cfg_frame_len);
          m_cnt   = 0;
          m_acc   = 0;
          m_phase = 1;
        end
        1: if (in_valid) begin
          m_acc += vsum(vector_in);
          m_tv   = vector_in;
          m_cnt++;
          if (m_cnt == m_len) begin
            m_phase = 2;
            done_at = cyc + LAT + 2;
          end
        end
        2: if (cyc == done_at) begin
          m_fs    = ACC_W'(m_acc);
          m_phase = 3;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic check(string nm, logic [127:0] act,
                       logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 128'(in_ready), 128'(m_phase == 1));
      check("busy", 128'(busy), 128'(m_phase != 0));
      check("out_valid", 128'(out_valid), 128'(m_phase == 3));
      check("frame_sum", 128'(frame_sum), 128'(m_fs));
      check("tree_vector", 128'(tree_vector), 128'(m_tv));
    end
  end

  task automatic pulse_start(logic [FW-1:0] len);
    @(negedge clk);
    start = 1'b1;
    cfg_frame_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [VW-1:0] v);
    in_valid  = 1'b1;
    vector_in = v;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      bad++;
      $display("FAIL wait_out: out_valid timeout");
    end
  endtask

  int n;
  int ovc;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};
  logic [VW-1:0] pv [3];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_frame_len = '0;
    in_valid = 1'b0;
    vector_in = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_frame_sum", 128'(frame_sum), 128'(0));
    check("rst_tree_vector", 128'(tree_vector), 128'(0));
    chk_en = 1'b1;
    rst_n = 1'b1;

    // single vector 1..7
    pulse_start(8'd1);
    send(ramp());
    wait_out(n);
    check("len1_latency", 128'(n), 128'(LAT + 2));
    check("len1_sum", 128'(frame_sum), 128'(28));
    ovc = 1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check("len1_ov_cycles", 128'(ovc), 128'(1));

    // four all-ones vectors, extra in_valid after last is ignored
    pulse_start(8'd4);
    repeat (4) send(fill(16'hFFFF));
    check("len4_ready_low", 128'(in_ready), 128'(0));
    send(ramp());
    wait_out(n);
    check("len4_sum", 128'(frame_sum), 128'(1834980));
    @(negedge clk);

    // backpressure with a start during HOLD
    out_ready = 1'b0;
    pulse_start(8'd4);
    repeat (4) send(fill(16'hFFFF));
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      cfg_frame_len = 8'd1;
      @(negedge clk);
      check("hold_ov", 128'(out_valid), 128'(1));
      check("hold_sum", 128'(frame_sum), 128'(1834980));
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release", 128'({out_valid, busy}), 128'(0));

    // gapped input: 28 + 7*4096 + 21
    pv[0] = ramp();
    pv[1] = fill(16'h1000);
    pv[2] = fill(16'd3);
    pulse_start(8'd3);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) begin
        send(pv[n]);
        n++;
      end else begin
        vector_in = fill(16'hFFFF);
        @(negedge clk);
      end
    end
    wait_out(n);
    check("gap_sum", 128'(frame_sum), 128'(28721));

    // abort with two vectors in flight
    pulse_start(8'd4);
    send(fill(16'h0100));
    send(fill(16'h0100));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_tree_vector", 128'(tree_vector), 128'(0));
    pulse_start(8'd1);
    send(fill(16'd1));
    wait_out(n);
    check("abort_new_sum", 128'(frame_sum), 128'(7));

    // back-to-back start right after the HOLD handshake, len 0
    pulse_start(8'd0);
    check("len0_busy", 128'(busy), 128'(1));
    send(fill(16'd2));
    check("len0_ready_low", 128'(in_ready), 128'(0));
    wait_out(n);
    check("len0_sum", 128'(frame_sum), 128'(14));
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_frame_ctrl.md
VECTOR_FRAME_CTRL -- requirements
Module: vector_frame_ctrl

Interface
REQ-001 Parameter VECTOR_LENGTH, default 7: elements per vector.
REQ-002 Parameter DATA_WIDTH, default 16: unsigned element width.
REQ-003 Parameter FRAME_W, default 8: width of the frame-length configuration.
REQ-004 Derived: LAT = clog2(VECTOR_LENGTH), SUM_W = DATA_WIDTH+LAT, ACC_W = SUM_W+FRAME_W.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a frame when the FSM is IDLE.
REQ-008 cfg_frame_len  in  FRAME_W  vectors per frame, sampled on an accepted start.
REQ-009 in_valid  in  1  input vector valid.
REQ-010 in_ready  out  1  controller accepts an input vector.
REQ-011 vector_in  in  VECTOR_LENGTH*DATA_WIDTH  packed input vector.
REQ-012 tree_vector  out  VECTOR_LENGTH*DATA_WIDTH  registered drive to the external pipelined adder tree.
REQ-013 tree_sum  in  SUM_W  adder-tree result, valid LAT cycles after tree_vector changes.
REQ-014 out_valid  out  1  frame_sum valid.
REQ-015 out_ready  in  1  consumer accepts frame_sum.
REQ-016 frame_sum  out  ACC_W  sum of all elements of all vectors in the frame.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and HOLD.
REQ-019 IDLE: in_ready=0; start=1 SHALL latch cfg_frame_len (0 treated as 1), clear the accumulator and issue count, and go to RUN.
REQ-020 RUN: in_ready=1; each in_valid&in_ready edge SHALL load vector_in into tree_vector, set bit 0 of a (LAT+1)-bit valid pipe, and increment the issue count.
REQ-021 The handshake that issues the last vector (count reaches frame_len) SHALL move the FSM to DRAIN, so in_ready is 0 from the next cycle.
REQ-022 Without a handshake, tree_vector SHALL hold its value and valid-pipe bit 0 SHALL be 0.
REQ-023 The valid pipe SHALL shift every cycle; when bit LAT is 1, tree_sum SHALL be zero-extended to ACC_W and added into the accumulator on that edge.
REQ-024 Latency: a vector accepted at edge k SHALL be accumulated at edge k+LAT+1.
REQ-025 DRAIN: when the valid pipe is all zero, frame_sum SHALL load the accumulator, out_valid SHALL rise, and the FSM SHALL go to HOLD.
REQ-026 HOLD: out_valid=1 and frame_sum stable until out_valid&out_ready; on that edge out_valid SHALL drop and the FSM SHALL return to IDLE.
REQ-027 start SHALL be ignored in RUN, DRAIN and HOLD.
REQ-028 in_valid outside RUN SHALL be ignored, with no effect on count, pipe or tree_vector.
REQ-029 Arithmetic SHALL be unsigned and non-saturating; ACC_W guarantees no overflow for frame_len up to 2^FRAME_W-1 at all-ones data.
REQ-030 A back-to-back start in the cycle after the HOLD handshake SHALL be accepted normally.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: FSM IDLE, in_ready=0, out_valid=0, busy=0, frame_sum=0, accumulator=0, issue count=0, valid pipe=0, tree_vector=0.
REQ-032 Reset in RUN or DRAIN SHALL abort the frame; in-flight tree results SHALL be discarded and SHALL NOT reach a later frame's accumulator.

Verification (VECTOR_LENGTH=7, DATA_WIDTH=16, FRAME_W=8, LAT=3)
REQ-033 start with cfg_frame_len=1, one vector of elements 1..7, out_ready=1 -> accumulated 4 cycles after the handshake; frame_sum=28, out_valid high exactly 1 cycle, then IDLE.
REQ-034 cfg_frame_len=4, four vectors of all 16'hFFFF back-to-back -> frame_sum=4*7*65535=1834980; in_ready low from the cycle after the 4th handshake.
REQ-035 Same frame with out_ready=0 for 10 cycles -> out_valid and frame_sum stable for those 10 cycles, a start pulse during HOLD is ignored, and IDLE follows the handshake.
REQ-036 cfg_frame_len=3 with in_valid gaps (pattern 1,0,0,1,0,1) -> count and sum correct, frame_sum = sum of the 3 vectors, and no accumulation from the idle cycles.
REQ-037 rst_n=0 for 1 cycle while 2 vectors are in flight, then a new frame with cfg_frame_len=1 and vector all 1s -> frame_sum=7, no residue from the aborted frame.
REQ-038 cfg_frame_len=0 with vector all 2s -> treated as 1 and frame_sum=14.
